// File: rtl/game_timer.sv
// game_timer: match clock for the tank game. Counts frame_clk ticks into
// three BCD second digits, freezes on a tank kill, flags the draw limit,
// and decodes the screen regions where the three digit glyphs are drawn.
module game_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int LIMIT_HUND     = 2,
  parameter int LIMIT_TEN      = 5,
  parameter int LIMIT_ONE      = 0,
  parameter int HUND_X         = 540,
  parameter int TEN_X          = 572,
  parameter int ONE_X          = 604,
  parameter int TIMER_Y        = 0,
  parameter int DIGIT_W        = 32,
  parameter int DIGIT_H        = 32
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       pause,
  input  logic       tank1_alive,
  input  logic       tank2_alive,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] hund_sec,
  output logic [3:0] ten_sec,
  output logic [3:0] one_sec,
  output logic       time_up,
  output logic       tick_1hz,
  output logic       running,
  output logic       is_timer_hund,
  output logic       is_timer_ten,
  output logic       is_timer_one
);

  // A prescaler of at least one bit keeps FRAMES_PER_SEC = 1 legal.
  localparam int PW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(FRAMES_PER_SEC - 1);

  localparam logic [3:0] LIM_H = 4'(LIMIT_HUND);
  localparam logic [3:0] LIM_T = 4'(LIMIT_TEN);
  localparam logic [3:0] LIM_O = 4'(LIMIT_ONE);

  // Region bounds widened to 11 bits so X+W never overflows the compare.
  localparam logic [10:0] Y_LO  = 11'(TIMER_Y);
  localparam logic [10:0] Y_HI  = 11'(TIMER_Y + DIGIT_H);
  localparam logic [10:0] HX_LO = 11'(HUND_X);
  localparam logic [10:0] HX_HI = 11'(HUND_X + DIGIT_W);
  localparam logic [10:0] TX_LO = 11'(TEN_X);
  localparam logic [10:0] TX_HI = 11'(TEN_X + DIGIT_W);
  localparam logic [10:0] OX_LO = 11'(ONE_X);
  localparam logic [10:0] OX_HI = 11'(ONE_X + DIGIT_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE_KILL, DONE_TIME} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hund_q, hund_d, ten_q, ten_d, one_q, one_d;
  logic          time_up_q, time_up_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;

  logic [3:0]    inc_hund, inc_ten, inc_one;
  logic          limit_hit;
  logic          both_alive;

  // BCD +1 with ripple carry; 999 saturates instead of wrapping.
  always_comb begin
    inc_hund = hund_q;
    inc_ten  = ten_q;
    inc_one  = one_q;
    if (!(hund_q == 4'd9 && ten_q == 4'd9 && one_q == 4'd9)) begin
      if (one_q == 4'd9) begin
        inc_one = 4'd0;
        if (ten_q == 4'd9) begin
          inc_ten  = 4'd0;
          inc_hund = hund_q + 4'd1;
        end else begin
          inc_ten = ten_q + 4'd1;
        end
      end else begin
        inc_one = one_q + 4'd1;
      end
    end
  end

  assign limit_hit  = (inc_hund == LIM_H) && (inc_ten == LIM_T) && (inc_one == LIM_O);
  assign both_alive = tank1_alive && tank2_alive;

  // Next-state logic; rule order gives a kill priority over the limit.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hund_d    = hund_q;
    ten_d     = ten_q;
    one_d     = one_q;
    time_up_d = time_up_q;
    tick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          presc_d   = '0;
          hund_d    = 4'd0;
          ten_d     = 4'd0;
          one_d     = 4'd0;
          time_up_d = 1'b0;
        end
      end
      RUN: begin
        if (!both_alive) begin
          state_d = DONE_KILL;
        end else if (!pause) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            hund_d  = inc_hund;
            ten_d   = inc_ten;
            one_d   = inc_one;
            tick_d  = 1'b1;
            if (limit_hit) begin
              state_d   = DONE_TIME;
              time_up_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      DONE_KILL, DONE_TIME: begin
        if (start && both_alive) begin
          state_d   = RUN;
          presc_d   = '0;
          hund_d    = 4'd0;
          ten_d     = 4'd0;
          one_d     = 4'd0;
          time_up_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  // State and registered outputs, cleared asynchronously by Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      hund_q    <= 4'd0;
      ten_q     <= 4'd0;
      one_q     <= 4'd0;
      time_up_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hund_q    <= hund_d;
      ten_q     <= ten_d;
      one_q     <= one_d;
      time_up_q <= time_up_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign hund_sec = hund_q;
  assign ten_sec  = ten_q;
  assign one_sec  = one_q;
  assign time_up  = time_up_q;
  assign tick_1hz = tick_q;
  assign running  = running_q;

  // Glyph region strobes: half-open boxes, purely from the pixel position.
  logic [10:0] x_ext, y_ext;
  logic        y_in;
  assign x_ext = {1'b0, DrawX};
  assign y_ext = {1'b0, DrawY};
  assign y_in  = (y_ext >= Y_LO) && (y_ext < Y_HI);

  assign is_timer_hund = y_in && (x_ext >= HX_LO) && (x_ext < HX_HI);
  assign is_timer_ten  = y_in && (x_ext >= TX_LO) && (x_ext < TX_HI);
  assign is_timer_one  = y_in && (x_ext >= OX_LO) && (x_ext < OX_HI);

endmodule
